// File: rtl/main_mem_arbiter.sv
// Two-port arbiter sharing one main-memory port: captures request pulses, grants one
// transaction at a time (round-robin, or port-0 priority with MEM_ARB_FIXED_PRIO_EN).
module main_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int WDATA_W = 32,
  parameter int LINE_W  = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  p0_addr,
  input  logic [WDATA_W-1:0] p0_wdata,
  input  logic               p0_rd_req,
  input  logic               p0_wr_req,
  output logic [LINE_W-1:0]  p0_rdata,
  output logic               p0_ready,
  input  logic [ADDR_W-1:0]  p1_addr,
  input  logic [WDATA_W-1:0] p1_wdata,
  input  logic               p1_rd_req,
  input  logic               p1_wr_req,
  output logic [LINE_W-1:0]  p1_rdata,
  output logic               p1_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  output logic               mem_rd_req,
  output logic               mem_wr_req,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  output logic               err_proto
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                grant_r, grant_s;
  logic                start_s, done_s;
  logic [1:0]          pend_r;
  logic [1:0]          is_wr_r;
  logic [ADDR_W-1:0]   addr0_r, addr1_r;
  logic [WDATA_W-1:0]  wdata0_r, wdata1_r;
  logic                cap0_s, cap1_s, viol_s;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [WDATA_W-1:0]  mem_wdata_r;
  logic                mem_rd_req_r, mem_wr_req_r;
  logic                p0_ready_r, p1_ready_r;
  logic [LINE_W-1:0]   p0_rdata_r, p1_rdata_r;
  logic                err_proto_r;

  // A pulse with both rd and wr, or arriving while the port is still outstanding, is dropped.
  assign cap0_s = (p0_rd_req ^ p0_wr_req) & ~pend_r[0];
  assign cap1_s = (p1_rd_req ^ p1_wr_req) & ~pend_r[1];
  assign viol_s = (p0_rd_req & p0_wr_req) | ((p0_rd_req | p0_wr_req) & pend_r[0]) |
                  (p1_rd_req & p1_wr_req) | ((p1_rd_req | p1_wr_req) & pend_r[1]);

`ifdef MEM_ARB_FIXED_PRIO_EN
`else
  logic rr_last_r;

  // Remembers the last granted port so a tie goes to the other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= 1'b1;
    end else if (start_s) begin
      rr_last_r <= grant_s;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end
`endif

  // Next-state and grant selection.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    start_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_r != 2'b00) begin
          start_s = 1'b1;
          state_s = ISSUE;
          if (pend_r == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            grant_s = 1'b0;
`else
            grant_s = ~rr_last_r;
`endif
          end else begin
            grant_s = pend_r[1];
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (mem_ready) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      grant_r <= 1'b0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
    end
  end

  // Per-port request latches and the sticky protocol flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r      <= 2'b00;
      is_wr_r     <= 2'b00;
      addr0_r     <= {ADDR_W{1'b0}};
      addr1_r     <= {ADDR_W{1'b0}};
      wdata0_r    <= {WDATA_W{1'b0}};
      wdata1_r    <= {WDATA_W{1'b0}};
      err_proto_r <= 1'b0;
    end else begin
      if (cap0_s) begin
        addr0_r    <= p0_addr;
        wdata0_r   <= p0_wr_req ? p0_wdata : {WDATA_W{1'b0}};
        is_wr_r[0] <= p0_wr_req;
        pend_r[0]  <= 1'b1;
      end else if (done_s && !grant_r) begin
        pend_r[0]  <= 1'b0;
      end
      if (cap1_s) begin
        addr1_r    <= p1_addr;
        wdata1_r   <= p1_wr_req ? p1_wdata : {WDATA_W{1'b0}};
        is_wr_r[1] <= p1_wr_req;
        pend_r[1]  <= 1'b1;
      end else if (done_s && grant_r) begin
        pend_r[1]  <= 1'b0;
      end
      err_proto_r <= err_proto_r | viol_s;
    end
  end

  // Memory-side pulse is loaded on the IDLE->ISSUE edge so it is high only in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {WDATA_W{1'b0}};
      mem_rd_req_r <= 1'b0;
      mem_wr_req_r <= 1'b0;
    end else if (start_s) begin
      mem_addr_r   <= grant_s ? addr1_r : addr0_r;
      mem_wdata_r  <= grant_s ? wdata1_r : wdata0_r;
      mem_rd_req_r <= ~is_wr_r[grant_s];
      mem_wr_req_r <= is_wr_r[grant_s];
    end else begin
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {WDATA_W{1'b0}};
      mem_rd_req_r <= 1'b0;
      mem_wr_req_r <= 1'b0;
    end
  end

  // Completion pulses and returned lines; writes leave the held line alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_ready_r <= 1'b0;
      p1_ready_r <= 1'b0;
      p0_rdata_r <= {LINE_W{1'b0}};
      p1_rdata_r <= {LINE_W{1'b0}};
    end else begin
      p0_ready_r <= done_s & ~grant_r;
      p1_ready_r <= done_s & grant_r;
      if (done_s && !grant_r && !is_wr_r[0]) begin
        p0_rdata_r <= mem_rdata;
      end
      if (done_s && grant_r && !is_wr_r[1]) begin
        p1_rdata_r <= mem_rdata;
      end
    end
  end

  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_rd_req = mem_rd_req_r;
  assign mem_wr_req = mem_wr_req_r;
  assign p0_ready   = p0_ready_r;
  assign p1_ready   = p1_ready_r;
  assign p0_rdata   = p0_rdata_r;
  assign p1_rdata   = p1_rdata_r;
  assign err_proto  = err_proto_r;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Scoreboard bench for main_mem_arbiter: stimulus pushes expected memory requests and
// completions, a negedge monitor pops and compares; a small memory model answers after mem_lat.
module tb_main_mem_arbiter;
  localparam int LW = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic p0_rd_req = 1'b0, p0_wr_req = 1'b0, p1_rd_req = 1'b0, p1_wr_req = 1'b0;
  logic [LW-1:0] p0_rdata, p1_rdata;
  logic p0_ready, p1_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_rd_req, mem_wr_req;
  logic [LW-1:0] mem_rdata = '0;
  logic mem_ready = 1'b0;
  logic err_proto;

  main_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic wr; int cyc; } mem_exp_t;
  typedef struct { logic port; logic [LW-1:0] rd0; logic [LW-1:0] rd1; int cyc; } rdy_exp_t;

  mem_exp_t exp_mem[$];
  rdy_exp_t exp_rdy[$];
  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_seen = 0;
  int mem_lat = 3;
  bit idle_noise = 1'b0;
  logic [LW-1:0] exp_rd0 = '0, exp_rd1 = '0;

  function automatic logic [LW-1:0] line_of(input logic [31:0] a);
    return {16{a ^ 32'h5A5A_A5A5}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: answers mem_lat cycles after a request pulse
  int cnt = 0;
  logic [31:0] maddr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt = 0;
      mem_ready = 1'b0;
    end else begin
      mem_ready = 1'b0;
      if (idle_noise) begin
        mem_ready = cyc[0];
        mem_rdata = {16{32'(cyc)}};
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = line_of(maddr);
        end
      end
      if (mem_rd_req | mem_wr_req) begin
        cnt = mem_lat;
        maddr = mem_addr;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    mem_exp_t m;
    rdy_exp_t r;
    if (rst_n) begin
      if (mem_rd_req | mem_wr_req) begin
        chk("mem_expected", exp_mem.size() != 0, 1'b1);
        if (exp_mem.size() != 0) begin
          m = exp_mem.pop_front();
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_wdata", mem_wdata, m.wdata);
          chk("mem_wr_req", mem_wr_req, m.wr);
          chk("mem_rd_req", mem_rd_req, !m.wr);
          if (m.cyc >= 0) chk("mem_cycle", cyc, m.cyc);
        end
      end else begin
        chk("mem_idle_zero", {mem_addr, mem_wdata}, '0);
      end
      if (p0_ready | p1_ready) begin
        rdy_seen++;
        chk("ready_expected", exp_rdy.size() != 0, 1'b1);
        chk("single_ready", p0_ready & p1_ready, 1'b0);
        if (exp_rdy.size() != 0) begin
          r = exp_rdy.pop_front();
          chk("ready_port", p1_ready, r.port);
          chk("p0_rdata", p0_rdata, r.rd0);
          chk("p1_rdata", p1_rdata, r.rd1);
          if (r.cyc >= 0) chk("ready_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1, output int t);
    @(negedge clk);
    p0_rd_req = r0; p0_wr_req = w0; p0_addr = a0; p0_wdata = d0;
    p1_rd_req = r1; p1_wr_req = w1; p1_addr = a1; p1_wdata = d1;
    t = cyc;
    @(negedge clk);
    p0_rd_req = 1'b0; p0_wr_req = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_rd_req = 1'b0; p1_wr_req = 1'b0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic expect_txn(input logic port, wr, input logic [31:0] a, d, input int mc, rc);
    mem_exp_t m;
    rdy_exp_t r;
    m.addr = a; m.wdata = wr ? d : 32'h0; m.wr = wr; m.cyc = mc;
    exp_mem.push_back(m);
    if (!wr) begin
      if (port) exp_rd1 = line_of(a);
      else exp_rd0 = line_of(a);
    end
    r.port = port; r.rd0 = exp_rd0; r.rd1 = exp_rd1; r.cyc = rc;
    exp_rdy.push_back(r);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_mem.size() != 0 || exp_rdy.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", (exp_mem.size() == 0 && exp_rdy.size() == 0), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_mem.delete();
    exp_rdy.delete();
    exp_rd0 = '0;
    exp_rd1 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_mem"}, {mem_addr, mem_wdata, mem_rd_req, mem_wr_req}, '0);
    chk({tag, "_ready"}, {p0_ready, p1_ready}, '0);
    chk({tag, "_p0_rdata"}, p0_rdata, '0);
    chk({tag, "_p1_rdata"}, p1_rdata, '0);
    chk({tag, "_err"}, err_proto, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int t, r, n0, n1, b;
    logic [31:0] a0 [3];
    logic [31:0] a1 [3];
    logic        w1 [3];
    a0 = '{32'h0000_4000, 32'h0000_4040, 32'h0000_4080};
    a1 = '{32'h0000_8000, 32'h0000_8040, 32'h0000_8080};
    w1 = '{1'b0, 1'b1, 1'b0};

    // 1: reset state, memory noise in IDLE produces nothing
    do_reset();
    check_quiet("reset");
    r = rdy_seen;
    idle_noise = 1'b1;
    repeat (10) @(negedge clk);
    idle_noise = 1'b0;
    repeat (2) @(negedge clk);
    chk("noise_no_ready", rdy_seen, r);
    chk("noise_p0_rdata", p0_rdata, '0);

    // 2: single read, exact latency with L=3
    drive(1'b1, 1'b0, 32'h0000_1040, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, t);
    expect_txn(1'b0, 1'b0, 32'h0000_1040, 32'h0, t + 2, t + 6);
    wait_drain(50);

    // 3: simultaneous p0 read and p1 write from fresh arbitration state
    do_reset();
    drive(1'b1, 1'b0, 32'h0000_1080, 32'h0, 1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, t);
    expect_txn(1'b0, 1'b0, 32'h0000_1080, 32'h0, -1, -1);
    expect_txn(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, -1, -1);
    wait_drain(60);

    // 4: both re-request right after each ready -> grants alternate 0,1,0,1,0,1
    for (int k = 0; k < 3; k++) begin
      expect_txn(1'b0, 1'b0, a0[k], 32'h0, -1, -1);
      expect_txn(1'b1, w1[k], a1[k], 32'h1234_5678, -1, -1);
    end
    drive(1'b1, 1'b0, a0[0], 32'h0, 1'b1, 1'b0, a1[0], 32'h0, t);
    n0 = 1; n1 = 1; b = 0;
    while ((n0 < 3 || n1 < 3) && b < 300) begin
      @(negedge clk);
      b++;
      p0_rd_req = 1'b0; p1_rd_req = 1'b0; p1_wr_req = 1'b0;
      if (p0_ready && n0 < 3) begin
        p0_rd_req = 1'b1; p0_addr = a0[n0]; n0++;
      end
      if (p1_ready && n1 < 3) begin
        p1_rd_req = !w1[n1]; p1_wr_req = w1[n1]; p1_addr = a1[n1]; p1_wdata = 32'h1234_5678; n1++;
      end
    end
    @(negedge clk);
    p0_rd_req = 1'b0; p1_rd_req = 1'b0; p1_wr_req = 1'b0;
    chk("alt_all_issued", (n0 == 3 && n1 == 3), 1'b1);
    wait_drain(100);

    // 4b: after a lone p0 grant, a tie goes to p1
    drive(1'b1, 1'b0, 32'h0000_5000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, t);
    expect_txn(1'b0, 1'b0, 32'h0000_5000, 32'h0, -1, -1);
    wait_drain(50);
    drive(1'b1, 1'b0, 32'h0000_5040, 32'h0, 1'b1, 1'b0, 32'h0000_9000, 32'h0, t);
    expect_txn(1'b1, 1'b0, 32'h0000_9000, 32'h0, -1, -1);
    expect_txn(1'b0, 1'b0, 32'h0000_5040, 32'h0, -1, -1);
    wait_drain(60);

    // 5: protocol violations are flagged, sticky and dropped
    chk("err_before_viol", err_proto, 1'b0);
    drive(1'b1, 1'b0, 32'h0000_6000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, t);
    expect_txn(1'b0, 1'b0, 32'h0000_6000, 32'h0, -1, -1);
    drive(1'b1, 1'b0, 32'h0000_6100, 32'h0, 1'b1, 1'b1, 32'h0000_7000, 32'h0, t);
    chk("err_set", err_proto, 1'b1);
    wait_drain(50);
    repeat (10) @(negedge clk);
    chk("err_sticky", err_proto, 1'b1);

    // 6: reset during WAIT drops the transaction; a new request still works
    mem_lat = 6;
    drive(1'b1, 1'b0, 32'h0000_A000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, t);
    expect_txn(1'b0, 1'b0, 32'h0000_A000, 32'h0, t + 2, -1);
    while (cyc < t + 4) @(negedge clk);
    r = rdy_seen;
    do_reset();
    repeat (12) @(negedge clk);
    chk("midreset_no_ready", rdy_seen, r);
    check_quiet("after_midreset");
    mem_lat = 3;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, t);
    expect_txn(1'b1, 1'b0, 32'h0000_3000, 32'h0, t + 2, t + 6);
    wait_drain(50);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
